ifetch_queue: RTL and testbench

Parametrised instruction-fetch unit between the memory controller, the branch predictor, the dispatcher and the ROB. It holds a direct-mapped instruction cache with multi-word lines and follows the predicted path one instruction per cycle on hits. Fetched instructions are buffered in a `IQ_DEPTH`-entry FIFO, so fetch runs ahead of dispatch. A ROB redirect flushes the FIFO; a line fill that is already in progress still completes and is installed.

---
 rtl/ifetch_queue_if.sv | 41 ++++
 rtl/ifetch_queue.sv | 153 +++++++++++++++
 tb/tb_ifetch_queue.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_queue_if.sv
// Fetch-unit bundle: memory port, predictor port, instruction-queue head and redirect.
// The fetch unit takes the master side and its environment takes the slave side.
interface ifetch_queue_if;
    logic        rdy;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ok_i;
    logic [31:0] mem_data_i;
    logic [31:0] pred_pc_o;
    logic [31:0] pred_ins_o;
    logic        pred_taken_i;
    logic [31:0] pred_target_i;
    logic        iq_valid_o;
    logic [31:0] iq_ins_o;
    logic [31:0] iq_pc_o;
    logic        iq_pred_taken_o;
    logic [31:0] iq_pred_pc_o;
    logic        dsp_pop_i;
    logic        flush_i;
    logic [31:0] flush_pc_i;

    modport master (
        input  rdy,
        output mem_req_o, mem_addr_o,
        input  mem_ok_i, mem_data_i,
        output pred_pc_o, pred_ins_o,
        input  pred_taken_i, pred_target_i,
        output iq_valid_o, iq_ins_o, iq_pc_o, iq_pred_taken_o, iq_pred_pc_o,
        input  dsp_pop_i, flush_i, flush_pc_i
    );

    modport slave (
        output rdy,
        input  mem_req_o, mem_addr_o,
        output mem_ok_i, mem_data_i,
        input  pred_pc_o, pred_ins_o,
        output pred_taken_i, pred_target_i,
        input  iq_valid_o, iq_ins_o, iq_pc_o, iq_pred_taken_o, iq_pred_pc_o,
        output dsp_pop_i, flush_i, flush_pc_i
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch: direct-mapped I-cache, combinational predictor loop and an
// instruction FIFO that lets fetch run ahead of dispatch.
//
// state | meaning
// IDLE  | look up fpc; push on hit, start a line fill on miss
// FILL  | collect LINE_WORDS words from memory, then install the line
module ifetch_queue #(
    parameter int ICACHE_LINES = 16,
    parameter int LINE_WORDS   = 4,
    parameter int IQ_DEPTH     = 4
) (
    input logic          clk,
    input logic          rst,
    ifetch_queue_if.master bus
);

    localparam int WB      = $clog2(LINE_WORDS);
    localparam int IB      = $clog2(ICACHE_LINES);
    localparam int IDX_LSB = 2 + WB;
    localparam int TAGW    = 32 - IDX_LSB - IB;
    localparam int PW      = $clog2(IQ_DEPTH);
    localparam int CW      = PW + 1;

    typedef enum logic {IDLE, FILL} state_t;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] ppc;
    } iq_entry_t;

    state_t            state_q;
    logic [31:0]       fpc_q;
    logic [WB-1:0]     fill_cnt_q;
    logic              mem_req_q;
    logic [31:0]       mem_addr_q;
    logic [ICACHE_LINES-1:0] valid_q;
    logic [TAGW-1:0]   tag_q [ICACHE_LINES];
    logic [31:0]       line_data [ICACHE_LINES][LINE_WORDS];
    iq_entry_t         iq_mem [IQ_DEPTH];
    logic [PW-1:0]     head_q;
    logic [PW-1:0]     tail_q;
    logic [CW-1:0]     count_q;

    logic [IB-1:0]     cur_idx;
    logic [WB-1:0]     cur_word;
    logic [TAGW-1:0]   cur_tag;
    logic [IB-1:0]     fill_idx;
    logic [TAGW-1:0]   fill_tag;
    logic              tag_match;
    logic              iq_full;
    logic              do_push;
    logic              do_pop;
    logic              fill_wr;
    logic              fill_last;
    logic              start_fill;
    iq_entry_t         head_ent;

    assign cur_idx  = fpc_q[IDX_LSB +: IB];
    assign cur_word = fpc_q[2 +: WB];
    assign cur_tag  = fpc_q[31 -: TAGW];
    // The line being filled is identified by the request address, so a redirect
    // that moves fpc mid-fill cannot corrupt where the line is installed.
    assign fill_idx = mem_addr_q[IDX_LSB +: IB];
    assign fill_tag = mem_addr_q[31 -: TAGW];

    assign tag_match  = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);
    assign iq_full    = (count_q == CW'(IQ_DEPTH));
    assign do_push    = bus.rdy && (state_q == IDLE) && tag_match && !iq_full && !bus.flush_i;
    assign do_pop     = bus.rdy && bus.dsp_pop_i && (count_q != '0) && !bus.flush_i;
    assign start_fill = bus.rdy && (state_q == IDLE) && !tag_match && !bus.flush_i;
    assign fill_wr    = bus.rdy && (state_q == FILL) && bus.mem_ok_i;
    assign fill_last  = (fill_cnt_q == WB'(LINE_WORDS - 1));

    assign bus.pred_pc_o  = fpc_q;
    assign bus.pred_ins_o = line_data[cur_idx][cur_word];
    assign bus.mem_req_o  = mem_req_q;
    assign bus.mem_addr_o = mem_addr_q;

    assign head_ent            = iq_mem[head_q];
    assign bus.iq_valid_o      = (count_q != '0);
    assign bus.iq_ins_o        = bus.iq_valid_o ? head_ent.ins   : 32'd0;
    assign bus.iq_pc_o         = bus.iq_valid_o ? head_ent.pc    : 32'd0;
    assign bus.iq_pred_taken_o = bus.iq_valid_o ? head_ent.taken : 1'b0;
    assign bus.iq_pred_pc_o    = bus.iq_valid_o ? head_ent.ppc   : 32'd0;

    // Data arrays carry no reset; the valid bits and FIFO count gate them.
    always_ff @(posedge clk) begin
        if (fill_wr) begin
            line_data[fill_idx][fill_cnt_q] <= bus.mem_data_i;
            if (fill_last)
                tag_q[fill_idx] <= fill_tag;
        end
        if (do_push)
            iq_mem[tail_q] <= '{ins: bus.pred_ins_o, pc: fpc_q,
                                taken: bus.pred_taken_i, ppc: bus.pred_target_i};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fpc_q      <= 32'd0;
            fill_cnt_q <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'd0;
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else if (bus.rdy) begin
            if (bus.flush_i) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
                fpc_q   <= bus.flush_pc_i;
            end else begin
                if (do_push) begin
                    tail_q <= tail_q + PW'(1);
                    fpc_q  <= bus.pred_target_i;
                end
                if (do_pop)
                    head_q <= head_q + PW'(1);
                count_q <= count_q + CW'(do_push) - CW'(do_pop);
            end

            case (state_q)
                IDLE: begin
                    if (start_fill) begin
                        state_q          <= FILL;
                        fill_cnt_q       <= '0;
                        mem_req_q        <= 1'b1;
                        mem_addr_q       <= {fpc_q[31:IDX_LSB], {IDX_LSB{1'b0}}};
                        valid_q[cur_idx] <= 1'b0;
                    end
                end
                FILL: begin
                    if (bus.mem_ok_i) begin
                        fill_cnt_q <= fill_cnt_q + WB'(1);
                        mem_addr_q <= mem_addr_q + 32'd4;
                        if (fill_last) begin
                            valid_q[fill_idx] <= 1'b1;
                            mem_req_q         <= 1'b0;
                            state_q           <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: memory model, table predictor and a
// scoreboard monitor for dispatched entries and memory word requests.
module tb_ifetch_queue;

    localparam int MEM_LAT = 3;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] ppc;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    logic [31:0] taken_pc;
    logic [31:0] taken_tgt;
    logic mon_en;
    int   n_cmp  = 0;
    int   n_fail = 0;
    ent_t exp_iq[$];
    logic [31:0] exp_addr[$];

    ifetch_queue_if bus();

    ifetch_queue #(.ICACHE_LINES(16), .LINE_WORDS(4), .IQ_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.pred_taken_i  = (bus.pred_pc_o == taken_pc);
    assign bus.pred_target_i = bus.pred_taken_i ? taken_tgt : bus.pred_pc_o + 32'd4;

    function automatic logic [31:0] ins_at(input logic [31:0] a);
        return {a[19:0], 12'h013};
    endfunction

    function automatic ent_t mk(input logic [31:0] pc, input logic tk, input logic [31:0] ppc);
        ent_t e;
        e.ins = ins_at(pc); e.pc = pc; e.taken = tk; e.ppc = ppc;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_nt(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++)
            exp_iq.push_back(mk(base + 32'(4 * i), 1'b0, base + 32'(4 * i) + 32'd4));
    endtask

    task automatic push_addr(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++)
            exp_addr.push_back(base + 32'(4 * i));
    endtask

    // memory: each word answers MEM_LAT cycles after it is presented
    initial begin
        int lat;
        lat = 0;
        bus.mem_ok_i   = 1'b0;
        bus.mem_data_i = 32'd0;
        forever begin
            tick();
            if (bus.mem_ok_i) begin
                bus.mem_ok_i = 1'b0;
                lat = 0;
            end else if (bus.mem_req_o) begin
                lat++;
                if (lat == MEM_LAT) begin
                    bus.mem_ok_i   = 1'b1;
                    bus.mem_data_i = ins_at(bus.mem_addr_o);
                end
            end
        end
    end

    // monitor: compares every consumed head and every returned word request
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (mon_en && bus.rdy && !rst) begin
                if (bus.iq_valid_o && bus.dsp_pop_i) begin
                    if (exp_iq.size() == 0) begin
                        chk("iq_unexpected_pc", bus.iq_pc_o, 32'hDEAD_DEAD);
                    end else begin
                        e = exp_iq.pop_front();
                        chk("iq_pc", bus.iq_pc_o, e.pc);
                        chk("iq_ins", bus.iq_ins_o, e.ins);
                        chk("iq_pred_taken", {31'd0, bus.iq_pred_taken_o}, {31'd0, e.taken});
                        chk("iq_pred_pc", bus.iq_pred_pc_o, e.ppc);
                    end
                end
                if (bus.mem_ok_i) begin
                    chk("mem_req_during_ok", {31'd0, bus.mem_req_o}, 32'd1);
                    if (exp_addr.size() == 0)
                        chk("mem_addr_unexpected", bus.mem_addr_o, 32'hDEAD_DEAD);
                    else
                        chk("mem_addr", bus.mem_addr_o, exp_addr.pop_front());
                end
            end
        end
    end

    initial begin
        int t;
        rst            = 1'b1;
        mon_en         = 1'b1;
        bus.rdy        = 1'b1;
        bus.dsp_pop_i  = 1'b0;
        bus.flush_i    = 1'b0;
        bus.flush_pc_i = 32'd0;
        taken_pc       = 32'hFFFF_FFF0;
        taken_tgt      = 32'd0;
        repeat (3) tick();

        @(negedge clk);
        chk("rst_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
        chk("rst_iq_valid", {31'd0, bus.iq_valid_o}, 32'd0);
        chk("rst_iq_pc", bus.iq_pc_o, 32'd0);
        chk("rst_fpc", bus.pred_pc_o, 32'd0);

        // cold miss, then streaming not-taken hits through lines 0x0 and 0x10
        tick();
        rst = 1'b0;
        bus.dsp_pop_i = 1'b1;
        push_addr(32'h00, 12);
        push_addr(32'h80, 4);
        push_nt(32'h00, 8);
        push_nt(32'h80, 4);
        @(negedge clk);
        chk("req_before_edge", {31'd0, bus.mem_req_o}, 32'd0);
        @(negedge clk);
        chk("req_one_after_rst", {31'd0, bus.mem_req_o}, 32'd1);
        chk("first_req_addr", bus.mem_addr_o, 32'h0);

        // redirect while word 2 of line 0x20 is outstanding
        tick();
        for (t = 0; t < 600 && !(bus.mem_req_o && bus.mem_addr_o == 32'h28); t++) tick();
        chk("wait_word2_of_0x20", {31'd0, t < 600}, 32'd1);
        bus.flush_i    = 1'b1;
        bus.flush_pc_i = 32'h80;
        tick();
        bus.flush_i = 1'b0;
        @(negedge clk);
        chk("flush_fill_iq_empty", {31'd0, bus.iq_valid_o}, 32'd0);
        chk("flush_fill_req_kept", {31'd0, bus.mem_req_o}, 32'd1);
        chk("flush_fill_fpc", bus.pred_pc_o, 32'h80);

        // redirect into the installed 0x20 line with dispatch stalled; 0x28 is predicted taken to 0x0
        tick();
        for (t = 0; t < 600 && !(bus.mem_req_o && bus.mem_addr_o == 32'h90); t++) tick();
        chk("wait_fill_0x90", {31'd0, t < 600}, 32'd1);
        bus.dsp_pop_i  = 1'b0;
        bus.flush_i    = 1'b1;
        bus.flush_pc_i = 32'h20;
        taken_pc       = 32'h28;
        taken_tgt      = 32'h0;
        push_addr(32'h90, 4);
        exp_iq.push_back(mk(32'h20, 1'b0, 32'h24));
        exp_iq.push_back(mk(32'h24, 1'b0, 32'h28));
        exp_iq.push_back(mk(32'h28, 1'b1, 32'h00));
        tick();
        bus.flush_i = 1'b0;
        for (t = 0; t < 600 && bus.mem_req_o; t++) tick();
        chk("wait_fill_0x90_done", {31'd0, t < 600}, 32'd1);
        repeat (10) tick();
        @(negedge clk);
        chk("full_iq_valid", {31'd0, bus.iq_valid_o}, 32'd1);
        chk("full_head_pc", bus.iq_pc_o, 32'h20);
        chk("full_fpc_holds", bus.pred_pc_o, 32'h4);
        chk("full_no_fill", {31'd0, bus.mem_req_o}, 32'd0);

        // one pop from full: no push on the pop edge, push one cycle later
        tick();
        bus.dsp_pop_i = 1'b1;
        tick();
        bus.dsp_pop_i = 1'b0;
        @(negedge clk);
        chk("pop_edge_fpc_holds", bus.pred_pc_o, 32'h4);
        @(negedge clk);
        chk("push_after_pop_fpc", bus.pred_pc_o, 32'h8);

        // pop while full, then flush in a cycle that would also hit and pop
        tick();
        bus.dsp_pop_i = 1'b1;
        tick();
        bus.flush_i    = 1'b1;
        bus.flush_pc_i = 32'h0;
        taken_pc       = 32'h8;
        taken_tgt      = 32'h40;
        exp_iq.push_back(mk(32'h0, 1'b0, 32'h4));
        exp_iq.push_back(mk(32'h4, 1'b0, 32'h8));
        exp_iq.push_back(mk(32'h8, 1'b1, 32'h40));
        push_nt(32'h40, 4);
        push_addr(32'h40, 5);
        tick();
        bus.flush_i = 1'b0;
        @(negedge clk);
        chk("flush_hit_iq_empty", {31'd0, bus.iq_valid_o}, 32'd0);
        chk("flush_hit_fpc", bus.pred_pc_o, 32'h0);

        tick();
        for (t = 0; t < 3000 && (exp_iq.size() != 0 || exp_addr.size() != 0); t++) tick();
        chk("scoreboard_drained", {31'd0, t < 3000}, 32'd1);
        mon_en = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
